// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 single-wire sensor controller.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RELEASE,
        ST_RESP_LO,
        ST_RESP_HI,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_CHECK
    } dht11_state_e;

    localparam int unsigned FRAME_BITS    = 40;
    localparam int unsigned BYTE_HUM_INT  = 0;
    localparam int unsigned BYTE_HUM_DEC  = 1;
    localparam int unsigned BYTE_TEMP_INT = 2;
    localparam int unsigned BYTE_TEMP_DEC = 3;
    localparam int unsigned BYTE_CSUM     = 4;

    // Clock cycles per microsecond, never below one.
    function automatic int unsigned us_divisor(input int unsigned clk_hz);
        int unsigned div;
        div = clk_hz / 1_000_000;
        return (div == 0) ? 1 : div;
    endfunction

    // Byte idx of a frame shifted in MSB first (byte 0 arrives first).
    function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame,
                                              input int unsigned idx);
        return frame[FRAME_BITS-1-8*idx -: 8];
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Free-running divider producing a one-cycle pulse every microsecond.
module dht11_us_tick #(
    parameter int unsigned DIV = 50
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_sensor_if.sv
// DHT11 controller: periodic start pulse, response/bit timing, checksum
// validation, and presentation of the integer humidity/temperature bytes.
module dht11_sensor_if
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned POWERUP_US     = 1_000_000,
    parameter int unsigned POLL_US        = 2_000_000,
    parameter int unsigned START_LOW_US   = 18_000,
    parameter int unsigned BIT1_THRESH_US = 40,
    parameter int unsigned TIMEOUT_US     = 200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    inout  wire        dht11_data,
    output logic [7:0] temp_o,
    output logic [7:0] hum_o,
    output logic       done_o
);

    dht11_state_e          r_state;
    dht11_state_e          w_next;
    logic                  w_tick;
    logic [1:0]            r_sync;
    logic                  r_line_prev;
    logic                  w_rise;
    logic                  w_fall;
    logic [7:0]            r_phase;
    logic [20:0]           r_interval;
    logic [20:0]           w_interval_tgt;
    logic                  w_interval_hit;
    logic                  w_timeout;
    logic [FRAME_BITS-1:0] r_shift;
    logic [5:0]            r_bitcnt;
    logic                  w_last_bit;
    logic                  w_bit_val;
    logic                  r_first;
    logic [7:0]            w_sum;
    logic                  w_valid;
    logic                  w_drive_low;
    logic                  w_load;
    logic [7:0]            r_temp;
    logic [7:0]            r_hum;
    logic                  r_done;

    dht11_us_tick #(
        .DIV(us_divisor(CLK_FREQ_HZ))
    ) u_tick (
        .i_clk  (clk_i),
        .i_rst_n(rst_ni),
        .o_tick (w_tick)
    );

    // Open-drain pad: only ever pulled low, otherwise released to the pull-up.
    assign dht11_data = w_drive_low ? 1'b0 : 1'bz;

    assign w_rise = r_sync[1] & ~r_line_prev;
    assign w_fall = ~r_sync[1] & r_line_prev;

    always_comb begin
        w_interval_tgt = 21'(POLL_US - 1);
        if (r_state == ST_START) begin
            w_interval_tgt = 21'(START_LOW_US - 1);
        end else if (r_first) begin
            w_interval_tgt = 21'(POWERUP_US - 1);
        end
    end

    assign w_interval_hit = w_tick && (r_interval == w_interval_tgt);
    assign w_timeout      = w_tick && (r_phase == 8'(TIMEOUT_US - 1));
    assign w_bit_val      = (r_phase > 8'(BIT1_THRESH_US));
    assign w_last_bit     = (r_bitcnt == 6'(FRAME_BITS - 1));

    assign w_sum   = frame_byte(r_shift, BYTE_HUM_INT) + frame_byte(r_shift, BYTE_HUM_DEC)
                   + frame_byte(r_shift, BYTE_TEMP_INT) + frame_byte(r_shift, BYTE_TEMP_DEC);
    assign w_valid = (w_sum == frame_byte(r_shift, BYTE_CSUM));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_interval_hit) w_next = ST_START;
            ST_START:   if (w_interval_hit) w_next = ST_RELEASE;
            ST_RELEASE: if (w_fall) w_next = ST_RESP_LO;
                        else if (w_timeout) w_next = ST_IDLE;
            ST_RESP_LO: if (w_rise) w_next = ST_RESP_HI;
                        else if (w_timeout) w_next = ST_IDLE;
            ST_RESP_HI: if (w_fall) w_next = ST_BIT_LO;
                        else if (w_timeout) w_next = ST_IDLE;
            ST_BIT_LO:  if (w_rise) w_next = ST_BIT_HI;
                        else if (w_timeout) w_next = ST_IDLE;
            ST_BIT_HI:  if (w_fall) w_next = w_last_bit ? ST_CHECK : ST_BIT_LO;
                        else if (w_timeout) w_next = ST_IDLE;
            ST_CHECK:   w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_drive_low = (r_state == ST_START);
        w_load      = (r_state == ST_CHECK) && w_valid;
    end

    // Edge detectors idle high so release after reset is not seen as a fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync      <= '1;
            r_line_prev <= 1'b1;
            r_phase     <= '0;
            r_interval  <= '0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_first     <= 1'b1;
        end else begin
            r_sync      <= {r_sync[0], dht11_data};
            r_line_prev <= r_sync[1];

            if (w_next != r_state) begin
                r_phase <= '0;
            end else if (w_tick && (r_phase != '1)) begin
                r_phase <= r_phase + 1'b1;
            end

            if (w_next != r_state) begin
                r_interval <= '0;
            end else if (w_tick && ((r_state == ST_IDLE) || (r_state == ST_START))) begin
                r_interval <= r_interval + 1'b1;
            end

            if (r_state == ST_START) begin
                r_first <= 1'b0;
            end

            if (r_state == ST_IDLE) begin
                r_bitcnt <= '0;
            end else if ((r_state == ST_BIT_HI) && w_fall) begin
                r_shift  <= {r_shift[FRAME_BITS-2:0], w_bit_val};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    // done_o is registered so the pulse coincides with the updated bytes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_temp <= '0;
            r_hum  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_hum  <= frame_byte(r_shift, BYTE_HUM_INT);
                r_temp <= frame_byte(r_shift, BYTE_TEMP_INT);
            end
        end
    end

    assign temp_o = r_temp;
    assign hum_o  = r_hum;
    assign done_o = r_done;

endmodule

// File: tb/tb_dht11_sensor_if.sv
// Bench for dht11_sensor_if: behavioural sensor plus a frame-level output model.
module tb_dht11_sensor_if;

    localparam int unsigned CLK_HZ     = 2_000_000;
    localparam int          CPU        = 2;
    localparam int          POWERUP_US = 100;
    localparam int          POLL_US    = 500;
    localparam int          START_US   = 20;
    localparam int          THRESH_US  = 40;
    localparam int          TIMEOUT_US = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sens_low = 1'b0;
    wire        dht11_data;
    logic [7:0] temp_o;
    logic [7:0] hum_o;
    logic       done_o;

    pullup (dht11_data);
    assign dht11_data = sens_low ? 1'b0 : 1'bz;

    dht11_sensor_if #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .POWERUP_US    (POWERUP_US),
        .POLL_US       (POLL_US),
        .START_LOW_US  (START_US),
        .BIT1_THRESH_US(THRESH_US),
        .TIMEOUT_US    (TIMEOUT_US)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .dht11_data(dht11_data),
        .temp_o    (temp_o),
        .hum_o     (hum_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: last accepted bytes, plus the frame currently on the wire.
    logic [7:0] m_hum = 8'd0;
    logic [7:0] m_temp = 8'd0;
    logic [7:0] p_hum = 8'd0;
    logic [7:0] p_temp = 8'd0;
    bit         p_valid = 1'b0;
    int         done_cnt = 0;

    int ref_t = 0;
    int gap_lo = 0;
    int gap_hi = 0;
    bit gap_chk = 1'b0;

    always @(negedge clk) begin
        checks++;
        if (done_o) begin
            done_cnt++;
            if (!p_valid) begin
                errors++;
                $display("FAIL done_unexpected: done_o=1 required 0 at cycle %0d", cyc);
            end else if (hum_o !== p_hum || temp_o !== p_temp) begin
                errors++;
                $display("FAIL done_data: hum=%0d temp=%0d required hum=%0d temp=%0d",
                         hum_o, temp_o, p_hum, p_temp);
            end
            if (p_valid) begin
                m_hum  = p_hum;
                m_temp = p_temp;
            end
            p_valid = 1'b0;
        end else if (hum_o !== m_hum || temp_o !== m_temp) begin
            errors++;
            $display("FAIL hold_outputs: hum=%0d temp=%0d required hum=%0d temp=%0d at cycle %0d",
                     hum_o, temp_o, m_hum, m_temp, cyc);
        end
    end

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * CPU) @(posedge clk);
    endtask

    task automatic wait_host_start(input int budget, output int t_fall, output int t_rel,
                                   output int low_len, output bit ok);
        ok = 1'b0;
        t_fall = 0;
        t_rel = 0;
        low_len = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dht11_data === 1'b0 && !sens_low) begin
                ok = 1'b1;
                t_fall = cyc;
                low_len = 1;
                break;
            end
        end
        if (!ok) return;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dht11_data === 1'b1) begin
                ok = 1'b1;
                t_rel = cyc;
                break;
            end
            low_len++;
        end
    endtask

    task automatic send_frame(input logic [39:0] f, input int abort_bit);
        @(posedge clk);
        wait_us(int'($urandom_range(20, 40)));
        sens_low = 1'b1;
        wait_us(80);
        sens_low = 1'b0;
        wait_us(80);
        for (int b = 0; b < 40; b++) begin
            sens_low = 1'b1;
            wait_us(int'($urandom_range(48, 55)));
            sens_low = 1'b0;
            if (b == abort_bit) begin
                wait_us(10);
                rst_n = 1'b0;
                m_hum = 8'd0;
                m_temp = 8'd0;
                p_valid = 1'b0;
                return;
            end
            if (f[39-b]) wait_us(int'($urandom_range(65, 75)));
            else wait_us(int'($urandom_range(22, 30)));
        end
        sens_low = 1'b1;
        wait_us(50);
        sens_low = 1'b0;
        wait_us(5);
    endtask

    task automatic do_frame(input string nm, input logic [39:0] f, input int abort_bit);
        logic [7:0] b0, b1, b2, b3, b4;
        int  s, tf, tr, ll, d0;
        bit  ok, valid;
        b0 = f[39:32];
        b1 = f[31:24];
        b2 = f[23:16];
        b3 = f[15:8];
        b4 = f[7:0];
        s = int'(b0) + int'(b1) + int'(b2) + int'(b3);
        valid = ((s % 256) == int'(b4));
        d0 = done_cnt;
        wait_host_start((POLL_US + TIMEOUT_US + 100) * CPU, tf, tr, ll, ok);
        check({nm, "_start_seen"}, int'(ok), 1);
        if (!ok) return;
        check({nm, "_no_done_between"}, done_cnt - d0, 0);
        check({nm, "_start_low_cycles"}, ll, START_US * CPU);
        if (gap_chk) begin
            check_range({nm, "_start_gap"}, tf - ref_t, gap_lo, gap_hi);
            gap_chk = 1'b0;
        end
        p_hum = b0;
        p_temp = b2;
        p_valid = valid;
        d0 = done_cnt;
        send_frame(f, abort_bit);
        if (abort_bit >= 0) return;
        repeat (4) @(posedge clk);
        check({nm, "_done_pulses"}, done_cnt - d0, valid ? 1 : 0);
    endtask

    task automatic do_silent();
        int tf, tr, ll;
        bit ok;
        wait_host_start((POLL_US + TIMEOUT_US + 100) * CPU, tf, tr, ll, ok);
        check("silent_start_seen", int'(ok), 1);
        check("silent_start_low_cycles", ll, START_US * CPU);
        ref_t = tr;
        gap_lo = (POLL_US + TIMEOUT_US) * CPU - 4;
        gap_hi = (POLL_US + TIMEOUT_US + 2) * CPU + 4;
        gap_chk = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ref_t = cyc;
        gap_lo = POWERUP_US * CPU - 4;
        gap_hi = (POWERUP_US + 2) * CPU + 4;
        gap_chk = 1'b1;
    endtask

    initial begin
        logic [7:0]  r0, r1, r2, r3, cs;
        logic [39:0] f;
        int tf, tr, ll;
        bit ok;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_hum", int'(hum_o), 0);
        check("reset_temp", int'(temp_o), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_line_released", (dht11_data === 1'b1) ? 1 : 0, 1);
        release_reset();

        do_frame("frame_a", 40'h19_00_19_00_32, -1);
        check("frame_a_hum", int'(hum_o), 25);
        check("frame_a_temp", int'(temp_o), 25);

        do_frame("bad_csum", 40'h19_00_19_00_33, -1);
        check("bad_csum_hum", int'(hum_o), 25);
        check("bad_csum_temp", int'(temp_o), 25);

        do_silent();

        do_frame("frame_c", 40'h3C_00_1E_00_5A, -1);
        check("frame_c_hum", int'(hum_o), 60);
        check("frame_c_temp", int'(temp_o), 30);

        do_frame("wrap_sum", 40'hFF_01_00_02_02, -1);
        check("wrap_sum_hum", int'(hum_o), 255);
        check("wrap_sum_temp", int'(temp_o), 0);

        for (int k = 0; k < 2; k++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            cs = r0 + r1 + r2 + r3;
            if ($urandom_range(0, 1) == 1) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            f = {r0, r1, r2, r3, cs};
            do_frame("random", f, -1);
        end

        do_frame("abort", 40'h3C_00_1E_00_5A, 20);
        @(negedge clk);
        check("abort_hum", int'(hum_o), 0);
        check("abort_temp", int'(temp_o), 0);
        check("abort_done", int'(done_o), 0);
        check("abort_line_released", (dht11_data === 1'b1) ? 1 : 0, 1);
        repeat (5) @(posedge clk);
        release_reset();
        wait_host_start((POWERUP_US + 100) * CPU, tf, tr, ll, ok);
        check("recover_start_seen", int'(ok), 1);
        check_range("recover_start_gap", tf - ref_t, gap_lo, gap_hi);
        check("recover_start_low_cycles", ll, START_US * CPU);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
